// File: rtl/ps_adc_avg.sv
// Power-supply ADC readback conditioner: channel filter, block averager
// and hysteretic over/under comparison against the UFM reference.
module ps_adc_avg #(
    parameter logic [4:0] CHANNEL  = 5'd1,
    parameter int         AVG_LOG2 = 3,
    parameter logic [9:0] HYST     = 10'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        adc_valid,
    input  logic [4:0]  adc_channel,
    input  logic [11:0] adc_data,
    input  logic [9:0]  psRef,
    output logic [9:0]  psDig,
    output logic        psDig_valid,
    output logic        rdy,
    output logic        over,
    output logic        under
);

    localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int AW = 12 + AVG_LOG2;
    // With AVG_LOG2=0 the last count is 0, so every sample closes a block.
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    dig_q, dig_d;
    logic          val_q, val_d;
    logic          rdy_q, rdy_d;
    logic          over_q, over_d;
    logic          under_q, under_d;

    logic          accept;
    logic          last;
    logic [9:0]    dig_new;
    logic [10:0]   d11, ref11, hyst11;

    assign accept  = adc_valid && (adc_channel == CHANNEL) && enable;
    assign last    = (cnt_q == CNT_LAST);
    assign dig_new = 10'((acc_q + AW'(adc_data)) >> (AVG_LOG2 + 2));
    assign d11     = {1'b0, dig_new};
    assign ref11   = {1'b0, psRef};
    assign hyst11  = {1'b0, HYST};

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        val_d   = 1'b0;
        rdy_d   = rdy_q;
        over_d  = over_q;
        under_d = under_q;
        if (!enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
                dig_d = dig_new;
                val_d = 1'b1;
                rdy_d = 1'b1;
                if (d11 > ref11 + hyst11) begin
                    over_d = 1'b1;
                end else if (d11 <= ref11) begin
                    over_d = 1'b0;
                end
                if (d11 + hyst11 < ref11) begin
                    under_d = 1'b1;
                end else if (d11 >= ref11) begin
                    under_d = 1'b0;
                end
            end else begin
                acc_d = acc_q + AW'(adc_data);
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            val_q   <= 1'b0;
            rdy_q   <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            val_q   <= val_d;
            rdy_q   <= rdy_d;
            over_q  <= over_d;
            under_q <= under_d;
        end
    end

    assign psDig       = dig_q;
    assign psDig_valid = val_q;
    assign rdy         = rdy_q;
    assign over        = over_q;
    assign under       = under_q;

endmodule
